// File: rtl/dbns_pipe_adder.sv
// rtl/dbns_pipe_adder.sv - pipelined double-base (2^i*3^j) digit-grid adder with valid/ready flow control
module dbns_pipe_adder #(
  parameter int DW = 4,
  parameter int NB = 2,
  parameter int NT = 3
) (
  input  logic                   clock,
  input  logic                   reset_n,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [NB*NT*DW-1:0]    op_a,
  input  logic [NB*NT*DW-1:0]    op_b,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [NB*NT*DW-1:0]    sum_out,
  output logic [NT*(DW+1)-1:0]   carry_out,
  output logic                   overflow
);

  localparam int CW = NT * (DW + 1);

  logic [NB-1:0] vld;
  logic [NB-1:0] adv;
  logic [NB-1:0] load;
  logic          go;

  // Walk from the output back to the input: a stage advances when it holds
  // a beat and its successor is empty or advancing itself.
  always_comb begin
    adv = '0;
    go  = out_ready;
    for (int k = NB - 1; k >= 0; k--) begin
      adv[k] = vld[k] & go;
      go     = ~vld[k] | adv[k];
    end
    in_ready = go;
  end

  // Stage 0 loads on an accepted operand pair, later stages load when their
  // predecessor hands a beat over.
  always_comb begin
    load    = '0;
    load[0] = in_valid & in_ready;
    for (int k = 1; k < NB; k++) begin
      load[k] = adv[k-1];
    end
  end

  // Occupancy of each stage: filled on load, emptied when the beat moves on.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      vld <= '0;
    end else begin
      vld <= load | (vld & ~adv);
    end
  end

  // Stage k resolves row k. Its source holds the raw rows k..NB-1 with row k
  // in the low bits, so unconsumed rows shrink as the beat moves down; result
  // bits of rows 0..k are stored as single bits and widened at the output.
  for (genvar k = 0; k < NB; k++) begin : g_stage
    localparam int RW = (NB - k) * NT * DW;

    logic [RW-1:0]         a_s;
    logic [RW-1:0]         b_s;
    logic [CW-1:0]         c_s;
    logic [CW-1:0]         c_d;
    logic [CW-1:0]         c_q;
    logic [NT-1:0]         row_bits;
    logic [(k+1)*NT-1:0]   r_d;
    logic [(k+1)*NT-1:0]   r_q;
    logic [DW+1:0]         s;

    if (k == 0) begin : g_src
      assign a_s = op_a;
      assign b_s = op_b;
      assign c_s = '0;
      assign r_d = row_bits;
    end else begin : g_src
      assign a_s = g_stage[k-1].g_raw.a_q;
      assign b_s = g_stage[k-1].g_raw.b_q;
      assign c_s = g_stage[k-1].c_q;
      assign r_d = {row_bits, g_stage[k-1].r_q};
    end

    // Row-k cell arithmetic for every column: parity stays, half moves up.
    always_comb begin
      row_bits = '0;
      c_d      = '0;
      s        = '0;
      for (int j = 0; j < NT; j++) begin
        s = (DW+2)'(a_s[j*DW +: DW]) + (DW+2)'(b_s[j*DW +: DW])
          + (DW+2)'(c_s[j*(DW+1) +: DW+1]);
        row_bits[j]              = s[0];
        c_d[j*(DW+1) +: DW+1]    = s[DW+1:1];
      end
    end

    // Result bits and carries only change when a beat enters this stage.
    always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
        r_q <= '0;
        c_q <= '0;
      end else if (load[k]) begin
        r_q <= r_d;
        c_q <= c_d;
      end
    end

    if (k < NB - 1) begin : g_raw
      logic [RW-NT*DW-1:0] a_q;
      logic [RW-NT*DW-1:0] b_q;

      // Raw digits of the rows still to be resolved travel with the beat.
      always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
          a_q <= '0;
          b_q <= '0;
        end else if (load[k]) begin
          a_q <= a_s[RW-1:NT*DW];
          b_q <= b_s[RW-1:NT*DW];
        end
      end
    end
  end

  // Widen the final stage's single result bits back to DW-bit digits.
  always_comb begin
    sum_out = '0;
    for (int i = 0; i < NB; i++) begin
      for (int j = 0; j < NT; j++) begin
        sum_out[(i*NT+j)*DW +: DW] = DW'(g_stage[NB-1].r_q[i*NT+j]);
      end
    end
  end

  assign out_valid = vld[NB-1];
  assign carry_out = g_stage[NB-1].c_q;
  assign overflow  = vld[NB-1] & (|carry_out);

endmodule

// File: tb/tb_dbns_pipe_adder.sv
// tb/tb_dbns_pipe_adder.sv - randomized scoreboard bench for dbns_pipe_adder at two sizings
module tb_dbns_pipe_adder;

  localparam int DW  = 4;
  localparam int NB  = 2;
  localparam int NT  = 3;
  localparam int GW  = NB * NT * DW;
  localparam int CW  = NT * (DW + 1);
  localparam int DW2 = 2;
  localparam int NB2 = 4;
  localparam int NT2 = 1;
  localparam int GW2 = NB2 * NT2 * DW2;
  localparam int CW2 = NT2 * (DW2 + 1);

  logic          clock = 1'b0;
  logic          reset_n = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [GW-1:0] op_a = '0;
  logic [GW-1:0] op_b = '0;
  logic          out_valid;
  logic          out_ready = 1'b1;
  logic [GW-1:0] sum_out;
  logic [CW-1:0] carry_out;
  logic          overflow;

  logic           sw_in_valid = 1'b0;
  logic           sw_in_ready;
  logic [GW2-1:0] sw_a = '0;
  logic [GW2-1:0] sw_b = '0;
  logic           sw_out_valid;
  logic           sw_out_ready = 1'b1;
  logic [GW2-1:0] sw_sum;
  logic [CW2-1:0] sw_cy;
  logic           sw_ovf;

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;
  int n_pop = 0;
  int n_pop2 = 0;
  bit lat_chk = 1'b1;

  logic [63:0] q_sum[$], q_cy[$], q_a[$], q_b[$];
  int          q_acc[$];
  logic [63:0] q2_sum[$], q2_cy[$], q2_a[$], q2_b[$];
  logic [63:0] m_es, m_ec, m2_es, m2_ec;

  dbns_pipe_adder #(.DW(DW), .NB(NB), .NT(NT)) dut (
    .clock(clock), .reset_n(reset_n), .in_valid(in_valid), .in_ready(in_ready),
    .op_a(op_a), .op_b(op_b), .out_valid(out_valid), .out_ready(out_ready),
    .sum_out(sum_out), .carry_out(carry_out), .overflow(overflow)
  );

  dbns_pipe_adder #(.DW(DW2), .NB(NB2), .NT(NT2)) dut2 (
    .clock(clock), .reset_n(reset_n), .in_valid(sw_in_valid), .in_ready(sw_in_ready),
    .op_a(sw_a), .op_b(sw_b), .out_valid(sw_out_valid), .out_ready(sw_out_ready),
    .sum_out(sw_sum), .carry_out(sw_cy), .overflow(sw_ovf)
  );

  always #5 clock = ~clock;

  always @(posedge clock) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Column-wise ripple from the digit rules using plain integer arithmetic.
  function automatic void ref_add(input int dw, input int nb, input int nt,
                                  input logic [63:0] a, input logic [63:0] b,
                                  output logic [63:0] sum, output logic [63:0] cy);
    longint unsigned m, c, s;
    int p;
    sum = '0;
    cy  = '0;
    m   = (64'd1 << dw) - 1;
    for (int j = 0; j < nt; j++) begin
      c = 0;
      for (int i = 0; i < nb; i++) begin
        p   = (i * nt + j) * dw;
        s   = ((a >> p) & m) + ((b >> p) & m) + c;
        sum = sum | ((s % 2) << p);
        c   = s / 2;
      end
      cy = cy | (c << (j * (dw + 1)));
    end
  endfunction

  // Weighted column value of the operands must equal that of result plus carry.
  function automatic bit inv_ok(input int dw, input int nb, input int nt,
                                input logic [63:0] a, input logic [63:0] b,
                                input logic [63:0] sum, input logic [63:0] cy);
    longint unsigned m, lhs, rhs;
    int p;
    m = (64'd1 << dw) - 1;
    for (int j = 0; j < nt; j++) begin
      lhs = 0;
      rhs = ((cy >> (j * (dw + 1))) & ((64'd1 << (dw + 1)) - 1)) << nb;
      for (int i = 0; i < nb; i++) begin
        p   = (i * nt + j) * dw;
        lhs = lhs + ((((a >> p) & m) + ((b >> p) & m)) << i);
        rhs = rhs + (((sum >> p) & m) << i);
      end
      if (lhs != rhs) return 1'b0;
    end
    return 1'b1;
  endfunction

  // Default-size scoreboard: record accepts, compare the head while valid.
  always @(negedge clock) begin
    if (reset_n) begin
      if (in_valid && in_ready) begin
        ref_add(DW, NB, NT, 64'(op_a), 64'(op_b), m_es, m_ec);
        q_sum.push_back(m_es); q_cy.push_back(m_ec);
        q_a.push_back(64'(op_a)); q_b.push_back(64'(op_b)); q_acc.push_back(cyc);
      end
      if (out_valid) begin
        if (q_sum.size() == 0) begin
          check("spurious_beat", 1, 0);
        end else begin
          check("sum", 64'(sum_out), q_sum[0]);
          check("carry", 64'(carry_out), q_cy[0]);
          check("overflow", 64'(overflow), 64'(q_cy[0] != 0));
          if (out_ready) begin
            check("invariant", 64'(inv_ok(DW, NB, NT, q_a[0], q_b[0], 64'(sum_out), 64'(carry_out))), 1);
            if (lat_chk) check("latency", 64'(cyc - q_acc[0]), NB);
            void'(q_sum.pop_front()); void'(q_cy.pop_front());
            void'(q_a.pop_front()); void'(q_b.pop_front()); void'(q_acc.pop_front());
            n_pop++;
          end
        end
      end else begin
        check("ovf_idle", 64'(overflow), 0);
      end
    end
  end

  // Swept-size scoreboard.
  always @(negedge clock) begin
    if (reset_n) begin
      if (sw_in_valid && sw_in_ready) begin
        ref_add(DW2, NB2, NT2, 64'(sw_a), 64'(sw_b), m2_es, m2_ec);
        q2_sum.push_back(m2_es); q2_cy.push_back(m2_ec);
        q2_a.push_back(64'(sw_a)); q2_b.push_back(64'(sw_b));
      end
      if (sw_out_valid && sw_out_ready) begin
        if (q2_sum.size() == 0) begin
          check("sw_spurious_beat", 1, 0);
        end else begin
          check("sw_sum", 64'(sw_sum), q2_sum[0]);
          check("sw_carry", 64'(sw_cy), q2_cy[0]);
          check("sw_overflow", 64'(sw_ovf), 64'(q2_cy[0] != 0));
          check("sw_invariant", 64'(inv_ok(DW2, NB2, NT2, q2_a[0], q2_b[0], 64'(sw_sum), 64'(sw_cy))), 1);
          void'(q2_sum.pop_front()); void'(q2_cy.pop_front());
          void'(q2_a.pop_front()); void'(q2_b.pop_front());
          n_pop2++;
        end
      end
    end
  end

  task automatic send(input logic [GW-1:0] a, input logic [GW-1:0] b);
    bit acc;
    int budget;
    op_a = a; op_b = b; in_valid = 1'b1; acc = 1'b0; budget = 0;
    while (!acc && budget < 100) begin
      @(negedge clock); acc = in_ready;
      @(posedge clock); #1; budget++;
    end
    if (!acc) check("send_timeout", 0, 1);
    in_valid = 1'b0;
  endtask

  task automatic sw_send(input logic [GW2-1:0] a, input logic [GW2-1:0] b, input bit rnd_ready);
    bit acc;
    int budget;
    sw_a = a; sw_b = b; sw_in_valid = 1'b1; acc = 1'b0; budget = 0;
    while (!acc && budget < 100) begin
      if (rnd_ready) sw_out_ready = 1'($urandom % 2);
      @(negedge clock); acc = sw_in_ready;
      @(posedge clock); #1; budget++;
    end
    if (!acc) check("sw_send_timeout", 0, 1);
    sw_in_valid = 1'b0;
  endtask

  task automatic expect_out(input logic [GW-1:0] es, input logic [CW-1:0] ec, input logic eo);
    int n;
    n = 0;
    @(negedge clock);
    while (!out_valid && n < 20) begin
      @(negedge clock); n++;
    end
    check("dir_out_valid", 64'(out_valid), 1);
    check("dir_sum", 64'(sum_out), 64'(es));
    check("dir_carry", 64'(carry_out), 64'(ec));
    check("dir_overflow", 64'(overflow), 64'(eo));
    @(posedge clock); #1;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  initial begin
    int acc_cnt;
    int pops_before;
    repeat (2) @(posedge clock);
    #1;
    check("rst_out_valid", 64'(out_valid), 0);
    check("rst_in_ready", 64'(in_ready), 1);
    check("rst_sum", 64'(sum_out), 0);
    check("rst_carry", 64'(carry_out), 0);
    check("rst_overflow", 64'(overflow), 0);
    reset_n = 1'b1;
    idle(1);

    // Single low digit ripples into row 1.
    send(GW'(3), '0);
    expect_out(GW'(24'h001001), '0, 1'b0);

    // All digits at maximum: every column carries 22.
    send({NB*NT{4'hF}}, {NB*NT{4'hF}});
    expect_out(GW'(24'h111000), {NT{5'd22}}, 1'b1);
    idle(2);

    // Back-to-back stream with the sink always ready.
    for (int n = 0; n < 10; n++) send(GW'($urandom), GW'($urandom));
    idle(NB + 3);
    check("stream_drained", 64'(q_sum.size()), 0);

    // Stall the sink while the source keeps offering: only NB beats fit.
    lat_chk = 1'b0;
    out_ready = 1'b0;
    acc_cnt = 0;
    for (int n = 0; n < 5; n++) begin
      op_a = GW'($urandom); op_b = GW'($urandom); in_valid = 1'b1;
      @(negedge clock); if (in_ready) acc_cnt++;
      @(posedge clock); #1;
    end
    check("bp_accepts", 64'(acc_cnt), NB);
    check("bp_in_ready", 64'(in_ready), 0);
    in_valid = 1'b0;
    out_ready = 1'b1;
    idle(2 * NB + 2);
    check("bp_drained", 64'(q_sum.size()), 0);

    // Random source and sink activity.
    for (int n = 0; n < 300; n++) begin
      in_valid = 1'($urandom % 2); op_a = GW'($urandom); op_b = GW'($urandom);
      out_ready = 1'($urandom % 2);
      @(posedge clock); #1;
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    idle(2 * NB + 2);
    check("rand_drained", 64'(q_sum.size()), 0);
    lat_chk = 1'b1;

    // Reset with two beats in flight.
    send(GW'($urandom), GW'($urandom));
    send(GW'($urandom), GW'($urandom));
    reset_n = 1'b0;
    #1;
    check("mid_rst_out_valid", 64'(out_valid), 0);
    check("mid_rst_sum", 64'(sum_out), 0);
    check("mid_rst_carry", 64'(carry_out), 0);
    check("mid_rst_overflow", 64'(overflow), 0);
    check("mid_rst_in_ready", 64'(in_ready), 1);
    q_sum.delete(); q_cy.delete(); q_a.delete(); q_b.delete(); q_acc.delete();
    q2_sum.delete(); q2_cy.delete(); q2_a.delete(); q2_b.delete();
    @(posedge clock); #1;
    reset_n = 1'b1;
    pops_before = n_pop;
    send(GW'($urandom), GW'($urandom));
    idle(NB + 3);
    check("post_rst_beats", 64'(n_pop - pops_before), 1);

    // Swept sizing: all-max operands, then a long randomized run.
    sw_send({NB2{2'd3}}, {NB2{2'd3}}, 1'b0);
    idle(NB2 + 1);
    check("sw_max_beats", 64'(n_pop2), 1);
    sw_send({NB2{2'd3}}, {NB2{2'd3}}, 1'b0);
    repeat (NB2 - 1) @(posedge clock);
    #1;
    check("sw_max_valid", 64'(sw_out_valid), 1);
    check("sw_max_sum", 64'(sw_sum), 64'h44);
    check("sw_max_carry", 64'(sw_cy), 5);
    check("sw_max_overflow", 64'(sw_ovf), 1);
    idle(2);
    for (int n = 0; n < 1000; n++) begin
      sw_send(GW2'($urandom), GW2'($urandom), 1'b1);
      if ($urandom % 4 == 0) begin
        sw_out_ready = 1'($urandom % 2);
        @(posedge clock); #1;
      end
    end
    sw_out_ready = 1'b1;
    idle(2 * NB2 + 2);
    check("sw_drained", 64'(q2_sum.size()), 0);
    check("sw_beat_count", 64'(n_pop2), 1002);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
